// File: rtl/panel_buttons_pkg.sv
// Shared constants for the front-panel button conditioner: button indices,
// gating/repeat masks and the arbiter state encoding.
package panel_pkg;

    localparam int NUM_BTNS         = 6;
    localparam int BTN_STEP         = 0;
    localparam int BTN_EXAMINE      = 1;
    localparam int BTN_EXAMINE_NEXT = 2;
    localparam int BTN_DEPOSIT      = 3;
    localparam int BTN_DEPOSIT_NEXT = 4;
    localparam int BTN_RESET        = 5;

    localparam logic [NUM_BTNS-1:0] PAUSE_GATED_MASK = 6'b111110;
    localparam logic [NUM_BTNS-1:0] REPEAT_MASK      = 6'b010100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HELD    = 2'd1,
        ST_LOCKOUT = 2'd2
    } arb_state_e;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] lowest_set(input logic [NUM_BTNS-1:0] v);
        lowest_set = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

endpackage

// File: rtl/panel_buttons_if.sv
// Front-panel button bundle: raw buttons and pause switch in, conditioned
// levels and one-cycle press/release pulses out, plus arbiter state for debug.
interface panel_buttons_if;

    logic [panel_pkg::NUM_BTNS-1:0] btn_raw;
    logic                           pause_mode;
    logic [panel_pkg::NUM_BTNS-1:0] btn_level;
    logic [panel_pkg::NUM_BTNS-1:0] btn_press;
    logic [panel_pkg::NUM_BTNS-1:0] btn_release;
    logic                           busy;
    panel_pkg::arb_state_e          state_dbg;

    modport master (
        output btn_raw, pause_mode,
        input  btn_level, btn_press, btn_release, busy, state_dbg
    );

    modport slave (
        input  btn_raw, pause_mode,
        output btn_level, btn_press, btn_release, busy, state_dbg
    );

endinterface

// File: rtl/panel_buttons_debounce.sv
// One button: 2-flop synchroniser followed by a stability counter that flips
// the debounced level after DEBOUNCE_CYCLES consecutive differing samples.
module panel_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          meta_q, sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= raw;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any sample matching the current level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = ~level_q;
            else                                   cnt_d   = cnt_q + 1'b1;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/panel_buttons.sv
// Front-panel button conditioner: debounce, single-owner arbitration, pause
// gating. Optional auto-repeat on the *_NEXT buttons under PANEL_AUTO_REPEAT_EN.
module panel_buttons
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
`ifdef PANEL_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_RATE     = 2500000
`endif
) (
    input logic            clk,
    input logic            reset,
    panel_buttons_if.slave bus
);

    logic [NUM_BTNS-1:0] level, rise, rise_any, others, gate, owner_bit, sel_bit;
    logic [NUM_BTNS-1:0] lvl_prev_q;
    logic [NUM_BTNS-1:0] press_q, press_d, release_q, release_d, pend_q, pend_d;
    logic [2:0]          owner_q, owner_d, sel;
    arb_state_e          state_q, state_d;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_deb
        panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (bus.btn_raw[g]),
            .level (level[g])
        );
    end

`ifdef PANEL_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW     = $clog2(RPT_MAX) + 1;
    logic [RCW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic           rpt_first_q, rpt_first_d;
    logic           rpt_ok;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_prev_q <= '0;
            press_q    <= '0;
            release_q  <= '0;
            pend_q     <= '0;
            owner_q    <= '0;
            state_q    <= ST_IDLE;
        end else begin
            lvl_prev_q <= level;
            press_q    <= press_d;
            release_q  <= release_d;
            pend_q     <= pend_d;
            owner_q    <= owner_d;
            state_q    <= state_d;
        end
    end

`ifdef PANEL_AUTO_REPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`endif

    assign rise      = level & ~lvl_prev_q;
    // A rise seen on the cycle LOCKOUT exits is replayed from pend_q in IDLE.
    assign rise_any  = rise | pend_q;
    assign sel       = lowest_set(rise_any);
    assign sel_bit   = NUM_BTNS'(1) << sel;
    assign owner_bit = NUM_BTNS'(1) << owner_q;
    assign others    = level & ~owner_bit;
    assign gate      = bus.pause_mode ? '1 : ~PAUSE_GATED_MASK;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        press_d   = '0;
        release_d = '0;
        pend_d    = '0;
`ifdef PANEL_AUTO_REPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        rpt_ok      = REPEAT_MASK[owner_q] && bus.pause_mode;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|rise_any) begin
                    owner_d = sel;
                    press_d = sel_bit & gate;
                    state_d = ST_HELD;
`ifdef PANEL_AUTO_REPEAT_EN
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b1;
`endif
                end
            end
            ST_HELD: begin
                if (!level[owner_q]) begin
                    release_d = owner_bit & gate;
                    state_d   = (|others) ? ST_LOCKOUT : ST_IDLE;
                end
`ifdef PANEL_AUTO_REPEAT_EN
                else if (!rpt_ok) begin
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b1;
                end else if (rpt_cnt_q == (rpt_first_q ? RCW'(REPEAT_DELAY - 1)
                                                       : RCW'(REPEAT_RATE - 1))) begin
                    press_d     = owner_bit;
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b0;
                end else if (rpt_cnt_q != '1) begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
`endif
            end
            ST_LOCKOUT: begin
                if ((level & ~rise) == '0) begin
                    state_d = ST_IDLE;
                    pend_d  = rise;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_panel_buttons.sv
// Directed bench for panel_buttons with DEBOUNCE_CYCLES=4 (and REPEAT_DELAY=20,
// REPEAT_RATE=5 when PANEL_AUTO_REPEAT_EN is defined).
module tb_panel_buttons;
    import panel_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [5:0] acc_press;

    panel_buttons_if bus();

    panel_buttons #(
        .DEBOUNCE_CYCLES(4)
`ifdef PANEL_AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY(20),
        .REPEAT_RATE(5)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            acc_press |= bus.btn_press;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        acc_press   = '0;
        reset       = 1'b1;
        bus.btn_raw = '0;
        bus.pause_mode = 1'b1;
        tick(3);

        // reset state
        chk("rst_level", 32'(bus.btn_level), 32'h0);
        chk("rst_press", 32'(bus.btn_press), 32'h0);
        chk("rst_release", 32'(bus.btn_release), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
        reset = 1'b0;
        tick(2);

        // debounce latency: level after 6 edges, press on the 7th
        bus.btn_raw = 6'b000010;
        tick(5);
        chk("deb_level_early", 32'(bus.btn_level), 32'h0);
        tick(1);
        chk("deb_level", 32'(bus.btn_level), 32'h02);
        chk("deb_press_early", 32'(bus.btn_press), 32'h0);
        tick(1);
        chk("deb_press", 32'(bus.btn_press), 32'h02);
        chk("deb_busy", 32'(bus.busy), 32'h1);
        chk("deb_state", 32'(bus.state_dbg), 32'(ST_HELD));
        tick(1);
        chk("deb_press_once", 32'(bus.btn_press), 32'h0);
        chk("deb_busy_hold", 32'(bus.busy), 32'h1);
        bus.btn_raw = 6'b000000;
        tick(6);
        chk("rel_early", 32'(bus.btn_release), 32'h0);
        tick(1);
        chk("rel_pulse", 32'(bus.btn_release), 32'h02);
        chk("rel_busy", 32'(bus.busy), 32'h0);
        tick(1);
        chk("rel_once", 32'(bus.btn_release), 32'h0);

        // bounce rejection on DEPOSIT
        acc_press = '0;
        for (int i = 0; i < 10; i++) begin
            bus.btn_raw[3] = ~bus.btn_raw[3];
            tick(2);
        end
        chk("bounce_no_press", 32'(acc_press), 32'h0);
        chk("bounce_level", 32'(bus.btn_level), 32'h0);
        bus.btn_raw[3] = 1'b1;
        tick(6);
        chk("bounce_press_early", 32'(bus.btn_press), 32'h0);
        tick(1);
        chk("bounce_press", 32'(bus.btn_press), 32'h08);
        bus.btn_raw[3] = 1'b0;
        tick(7);
        chk("bounce_release", 32'(bus.btn_release), 32'h08);
        tick(2);

        // simultaneous press: lowest index wins, bit 4 never pressed
        acc_press = '0;
        bus.btn_raw = 6'b010100;
        tick(7);
        chk("sim_press", 32'(bus.btn_press), 32'h04);
        tick(2);
        bus.btn_raw = 6'b010000;
        tick(7);
        chk("sim_release2", 32'(bus.btn_release), 32'h04);
        chk("sim_lockout", 32'(bus.state_dbg), 32'(ST_LOCKOUT));
        bus.btn_raw = 6'b000000;
        tick(6);
        chk("sim_lockout_hold", 32'(bus.state_dbg), 32'(ST_LOCKOUT));
        tick(1);
        chk("sim_idle", 32'(bus.state_dbg), 32'(ST_IDLE));
        chk("sim_no_release4", 32'(bus.btn_release), 32'h0);
        chk("sim_only_press2", 32'(acc_press), 32'h04);
        tick(2);

        // pause gating
        bus.pause_mode = 1'b0;
        acc_press = '0;
        bus.btn_raw = 6'b000010;
        tick(7);
        chk("pause_exam_press", 32'(bus.btn_press), 32'h0);
        chk("pause_exam_held", 32'(bus.state_dbg), 32'(ST_HELD));
        bus.btn_raw = 6'b000000;
        tick(7);
        chk("pause_exam_release", 32'(bus.btn_release), 32'h0);
        chk("pause_exam_idle", 32'(bus.state_dbg), 32'(ST_IDLE));
        bus.btn_raw = 6'b000001;
        tick(7);
        chk("pause_step_press", 32'(bus.btn_press), 32'h01);
        bus.btn_raw = 6'b000000;
        tick(7);
        chk("pause_step_release", 32'(bus.btn_release), 32'h01);
        tick(2);
        acc_press = '0;
        bus.btn_raw = 6'b000010;
        tick(8);
        bus.pause_mode = 1'b1;
        tick(3);
        chk("pause_lift_no_press", 32'(acc_press), 32'h0);
        bus.btn_raw = 6'b000000;
        tick(8);
        chk("pause_lift_idle", 32'(bus.state_dbg), 32'(ST_IDLE));

        // auto-repeat on DEPOSIT_NEXT
        bus.btn_raw = 6'b010000;
        tick(7);
        chk("rpt_first", 32'(bus.btn_press), 32'h10);
        for (int k = 1; k < 40; k++) begin
            logic [5:0] exp_p;
            tick(1);
            exp_p = '0;
`ifdef PANEL_AUTO_REPEAT_EN
            if (k == 20 || k == 25 || k == 30 || k == 35) exp_p = 6'b010000;
`endif
            chk($sformatf("rpt_off%0d", k), 32'(bus.btn_press), 32'(exp_p));
        end
        bus.btn_raw = 6'b000000;
        tick(10);
        chk("rpt_idle", 32'(bus.state_dbg), 32'(ST_IDLE));

        // async reset mid-hold
        bus.btn_raw = 6'b000100;
        tick(7);
        chk("ar_press", 32'(bus.btn_press), 32'h04);
        tick(2);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_state", 32'(bus.state_dbg), 32'(ST_IDLE));
        chk("ar_level", 32'(bus.btn_level), 32'h0);
        chk("ar_busy", 32'(bus.busy), 32'h0);
        reset = 1'b0;
        tick(6);
        chk("ar_repress_early", 32'(bus.btn_press), 32'h0);
        tick(1);
        chk("ar_repress", 32'(bus.btn_press), 32'h04);
        bus.btn_raw = 6'b000000;
        tick(10);
        chk("ar_end_idle", 32'(bus.state_dbg), 32'(ST_IDLE));

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
